alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Operand-fetch and writeback stage that feeds the 64-bit combinational `alu`.
- Holds the 32-entry architectural register file.
- Accepts decoded instructions (op, rs1, rs2, rd, optional immediate) over a valid/ready handshake and registers operands and op into an EX register that drives the ALU.
- Captures the ALU result on the next edge, writes it back to the register file and reports it on a writeback port.
- Forwards the in-flight EX result to a back-to-back dependent instruction.

Parameters:
XLEN, 64, datapath and register width
NREG, 32, register count (index width = $clog2(NREG) = 5)
OPW, 5, ALU op width
CNTW, 32, retire counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  instruction offered
in_ready  output  1  stage can accept; equals !hold
in_op  input  OPW  ALU operation
in_rs1  input  5  source register A
in_rs2  input  5  source register B
in_rd  input  5  destination register
in_use_imm  input  1  1: operand B = in_imm instead of reg[rs2]
in_imm  input  XLEN  immediate operand
hold  input  1  freeze stage (downstream stall)
alu_a  output  XLEN  EX operand A to alu.a
alu_b  output  XLEN  EX operand B to alu.b
alu_op  output  OPW  EX op to alu.op
alu_result  input  XLEN  combinational result from alu
wb_valid  output  1  one-cycle pulse per retired instruction
wb_rd  output  5  retired destination
wb_data  output  XLEN  retired result
retire_count  output  CNTW  instructions retired since reset
dbg_addr  input  5  debug register-file read index
dbg_data  output  XLEN  combinational read of reg[dbg_addr]; 0 when dbg_addr == 0

Behaviour:
- Reset (rst = 1 at an edge):
  - All registers 0, ex_valid = 0.
  - alu_a, alu_b, alu_op = 0; wb_valid = 0, wb_rd = 0, wb_data = 0; retire_count = 0.
  - Reset mid-operation discards the EX instruction; no writeback occurs.
- Accept: an instruction is taken at an edge iff in_valid && in_ready.
  - EX register loads A, B, op and rd; ex_valid <= 1.
  - With no accept, ex_valid <= 0 unless hold = 1.
- Operand read for rsX, priority order:
  1. rsX == 0 -> 0.
  2. ex_valid && ex_rd == rsX && ex_rd != 0 -> alu_result (forward).
  3. Otherwise reg[rsX].
- Operand B: in_use_imm = 1 -> in_imm, bypassing B selection.
- Retire: at an edge with ex_valid && !hold:
  - reg[ex_rd] <= alu_result, except when ex_rd == 0 (register 0 is never written; it always reads 0).
  - wb_valid <= 1, wb_rd <= ex_rd, wb_data <= alu_result.
  - retire_count += 1, wrapping modulo 2^CNTW.
  - Otherwise wb_valid <= 0.
- Latency: accept at edge E -> ALU inputs valid during cycle E..E+1 -> wb_valid / reg update at edge E+1. Throughput is 1 instruction/cycle.
- Hold:
  - in_ready = 0; EX register, alu_a/b/op and ex_valid are frozen.
  - No retire; wb_valid = 0 from the next edge. Retire resumes on the first edge with hold = 0.
- Simultaneous retire and accept: the new instruction's operands use the forwarded alu_result, not the stale array value.
- Write and debug read to the same register in one cycle: dbg_data shows the old value until the edge.
- Register-file writes occur only via retire.

Test Plan:
- Bench stub drives alu_result = alu_a + alu_b, ignoring op.
1. Reset: assert rst for 2 cycles -> all outputs 0, in_ready = 1, dbg_data for every index = 0.
2. Load: issue rs1 = 0, use_imm = 1, imm = 5, rd = 1 -> one cycle later wb_valid = 1, wb_rd = 1, wb_data = 5; dbg_addr = 1 -> 5; retire_count = 1.
3. Forward: back-to-back r2 = r0 + 7, then r3 = r2 + r2 -> second wb_data = 14 (forwarded, not 0); reg[3] = 14.
4. Register 0: issue rd = 0 with imm = 9 -> wb_valid = 1, wb_data = 9; dbg_addr = 0 -> 0; a later read of r0 uses 0.
5. Hold: assert hold for 3 cycles with an instruction in EX -> in_ready = 0, wb_valid = 0, alu_a/b frozen; the instruction retires exactly once after release.
6. Reset mid-flight: accept an instruction, assert rst the next cycle -> no wb_valid, target register still 0, retire_count = 0.

Source files
------------

// File: rtl/alu_issue_if.sv
// Instruction issue channel into the ALU issue stage: decoded instruction
// fields offered with in_valid, accepted when in_ready is high.
interface alu_issue_if #(
    parameter int XLEN = 64,
    parameter int OPW  = 5,
    parameter int RW   = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  in_op;
    logic [RW-1:0]   in_rs1;
    logic [RW-1:0]   in_rs2;
    logic [RW-1:0]   in_rd;
    logic            in_use_imm;
    logic [XLEN-1:0] in_imm;

    // Decoder / instruction source side
    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
        input  in_ready
    );

    // Issue stage side
    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
        output in_ready
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand-fetch / writeback stage around a combinational ALU.
// Holds the architectural register file, registers operands into an EX
// stage that drives the ALU, retires the ALU result one edge later and
// forwards the in-flight EX result to a back-to-back dependent instruction.
module alu_issue_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int OPW  = 5,
    parameter int CNTW = 32,
    localparam int RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_if.slave      in_bus,
    input  logic            hold,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_valid,
    output logic [RW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [CNTW-1:0] retire_count,
    input  logic [RW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    // Architectural register file; entry 0 is never written.
    logic [XLEN-1:0] rf_q [NREG];

    // EX stage
    logic            ex_valid_q;
    logic [RW-1:0]   ex_rd_q;
    logic [XLEN-1:0] ex_a_q;
    logic [XLEN-1:0] ex_b_q;
    logic [OPW-1:0]  ex_op_q;

    // Writeback stage
    logic            wb_valid_q;
    logic [RW-1:0]   wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic [CNTW-1:0] retire_cnt_q;

    logic            accept;
    logic            retire;
    logic            fwd_ok;
    logic [XLEN-1:0] ex_a_d;
    logic [XLEN-1:0] ex_b_d;

    assign in_bus.in_ready = !hold;
    assign accept = in_bus.in_valid && !hold;
    assign retire = ex_valid_q && !hold;
    // Writes to r0 are dropped, so an EX instruction targeting r0 never forwards.
    assign fwd_ok = ex_valid_q && (ex_rd_q != '0);

    // Operand selection: r0 reads zero, then the in-flight EX result, then the array.
    always_comb begin
        ex_a_d = rf_q[in_bus.in_rs1];
        ex_b_d = rf_q[in_bus.in_rs2];
        if (in_bus.in_rs1 == '0) begin
            ex_a_d = '0;
        end else if (fwd_ok && (ex_rd_q == in_bus.in_rs1)) begin
            ex_a_d = alu_result;
        end
        if (in_bus.in_use_imm) begin
            ex_b_d = in_bus.in_imm;
        end else if (in_bus.in_rs2 == '0) begin
            ex_b_d = '0;
        end else if (fwd_ok && (ex_rd_q == in_bus.in_rs2)) begin
            ex_b_d = alu_result;
        end
    end

    // EX register: load on accept, drain when idle, freeze while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_op_q    <= '0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_rd_q    <= in_bus.in_rd;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_op_q    <= in_bus.in_op;
        end else if (!hold) begin
            ex_valid_q <= 1'b0;
        end
    end

    // Register file update from the retiring EX instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (retire && (ex_rd_q != '0)) begin
            rf_q[ex_rd_q] <= alu_result;
        end
    end

    // Writeback report: one-cycle pulse and wrapping retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            retire_cnt_q <= '0;
        end else if (retire) begin
            wb_valid_q   <= 1'b1;
            wb_rd_q      <= ex_rd_q;
            wb_data_q    <= alu_result;
            retire_cnt_q <= retire_cnt_q + 1'b1;
        end else begin
            wb_valid_q   <= 1'b0;
        end
    end

    assign alu_a        = ex_a_q;
    assign alu_b        = ex_b_q;
    assign alu_op       = ex_op_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign retire_count = retire_cnt_q;
    // Debug read sees the array before any same-cycle write lands.
    assign dbg_data     = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: ALU stub is a + b, expected
// writebacks are queued at accept and compared when wb_valid pulses.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [4:0]  alu_op;
    logic [63:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [31:0] retire_count;
    logic [4:0]  dbg_addr;
    logic [63:0] dbg_data;

    alu_issue_if #(.XLEN(64), .OPW(5), .RW(5)) ib ();

    alu_issue_stage #(.XLEN(64), .NREG(32), .OPW(5), .CNTW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_bus       (ib),
        .hold         (hold),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .retire_count (retire_count),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    assign alu_result = alu_a + alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;

    wb_t         sb_q [$];
    wb_t         mon_e;
    logic [63:0] mdl_rf [32];
    int unsigned exp_count;
    logic [63:0] last_a;
    logic [63:0] last_b;
    int          n_vec;
    int          n_bad;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction at the current negedge; returns at the next negedge.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic ui, input logic [63:0] imm);
        logic [63:0] a;
        logic [63:0] b;
        a = (rs1 == 5'd0) ? 64'd0 : mdl_rf[rs1];
        b = ui ? imm : ((rs2 == 5'd0) ? 64'd0 : mdl_rf[rs2]);
        last_a = a;
        last_b = b;
        ib.in_valid   = 1'b1;
        ib.in_rs1     = rs1;
        ib.in_rs2     = rs2;
        ib.in_rd      = rd;
        ib.in_use_imm = ui;
        ib.in_imm     = imm;
        ib.in_op      = 5'($urandom_range(0, 31));
        @(posedge clk);
        sb_q.push_back('{rd: rd, data: a + b});
        if (rd != 5'd0) mdl_rf[rd] = a + b;
        $display("issue rs1=%0d rs2=%0d rd=%0d imm=%0d use_imm=%0d exp=%0h", rs1, rs2, rd, imm, ui, a + b);
        @(negedge clk);
        ib.in_valid = 1'b0;
    endtask

    task automatic check_dbg(input logic [4:0] addr, input logic [63:0] exp);
        dbg_addr = addr;
        #1;
        check_eq($sformatf("dbg_r%0d", addr), dbg_data, exp);
    endtask

    // Writeback monitor: every pulse must match the oldest outstanding issue.
    always @(negedge clk) begin
        if (wb_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("wb_unexpected", {63'd0, wb_valid}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                exp_count++;
                $display("retire rd=%0d data=%0h count=%0d", wb_rd, wb_data, retire_count);
                check_eq("wb_rd", {59'd0, wb_rd}, {59'd0, mon_e.rd});
                check_eq("wb_data", wb_data, mon_e.data);
                check_eq("retire_count", {32'd0, retire_count}, {32'd0, exp_count});
            end
        end
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        exp_count = 0;
        for (int i = 0; i < 32; i++) mdl_rf[i] = 64'd0;
        rst = 1'b1;
        hold = 1'b0;
        dbg_addr = 5'd0;
        ib.in_valid = 1'b0;
        ib.in_op = 5'd0;
        ib.in_rs1 = 5'd0;
        ib.in_rs2 = 5'd0;
        ib.in_rd = 5'd0;
        ib.in_use_imm = 1'b0;
        ib.in_imm = 64'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_alu_a", alu_a, 64'd0);
        check_eq("rst_alu_b", alu_b, 64'd0);
        check_eq("rst_alu_op", {59'd0, alu_op}, 64'd0);
        check_eq("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check_eq("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
        check_eq("rst_wb_data", wb_data, 64'd0);
        check_eq("rst_retire_count", {32'd0, retire_count}, 64'd0);
        check_eq("rst_in_ready", {63'd0, ib.in_ready}, 64'd1);
        for (int i = 0; i < 32; i++) check_dbg(5'(i), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Load r1 = 5
        issue(5'd0, 5'd0, 5'd1, 1'b1, 64'd5);
        @(negedge clk);
        check_dbg(5'd1, 64'd5);
        check_eq("count_after_load", {32'd0, retire_count}, 64'd1);

        // Back-to-back dependency: r2 = 7, r3 = r2 + r2
        issue(5'd0, 5'd0, 5'd2, 1'b1, 64'd7);
        issue(5'd2, 5'd2, 5'd3, 1'b0, 64'd0);
        @(negedge clk);
        check_dbg(5'd3, 64'd14);

        // r0 target, then an r0 read right behind it must see 0
        issue(5'd0, 5'd0, 5'd0, 1'b1, 64'd9);
        issue(5'd0, 5'd3, 5'd7, 1'b0, 64'd0);
        @(negedge clk);
        check_dbg(5'd0, 64'd0);
        check_dbg(5'd7, 64'd14);

        // Hold with r4 = r1 + 10 sitting in EX; a competing offer must be refused
        issue(5'd1, 5'd0, 5'd4, 1'b1, 64'd10);
        hold = 1'b1;
        ib.in_valid = 1'b1;
        ib.in_rs1 = 5'd3;
        ib.in_rd = 5'd6;
        ib.in_use_imm = 1'b1;
        ib.in_imm = 64'd99;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("hold_in_ready", {63'd0, ib.in_ready}, 64'd0);
            check_eq("hold_wb_valid", {63'd0, wb_valid}, 64'd0);
            check_eq("hold_alu_a", alu_a, last_a);
            check_eq("hold_alu_b", alu_b, last_b);
            @(negedge clk);
        end
        check_eq("hold_alu_a_end", alu_a, last_a);
        check_eq("hold_wb_valid_end", {63'd0, wb_valid}, 64'd0);
        hold = 1'b0;
        ib.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_dbg(5'd4, 64'd15);
        check_dbg(5'd6, 64'd0);

        // Reset with r5 = 3 in EX: discarded
        issue(5'd0, 5'd0, 5'd5, 1'b1, 64'd3);
        rst = 1'b1;
        sb_q.delete();
        exp_count = 0;
        for (int i = 0; i < 32; i++) mdl_rf[i] = 64'd0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check_eq("midrst_count", {32'd0, retire_count}, 64'd0);
        check_dbg(5'd5, 64'd0);
        check_dbg(5'd1, 64'd0);
        @(negedge clk);
        check_eq("midrst_wb_valid2", {63'd0, wb_valid}, 64'd0);

        // Random dependent stream over r0..r7
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), {32'd0, $urandom});
        end

        // Drain with a bounded wait
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        check_eq("drain_empty", 64'(sb_q.size()), 64'd0);
        for (int i = 0; i < 8; i++) check_dbg(5'(i), mdl_rf[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
